// File: rtl/serial_add_ctrl_pkg.sv
// Shared types and helpers for the bit-serial adder sequencer.
// State encoding, default sizes and the full-adder cell.
package serial_add_ctrl_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Returns {carry, sum}.
  function automatic logic [1:0] fulladder(
    input logic x,
    input logic y,
    input logic ci
  );
    return {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

endpackage

// File: rtl/serial_shift_reg.sv
// Loadable right-shift register with serial input into the MSB.
// Load has priority over shift; reset clears the contents.
module serial_shift_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic             sin,
  input  logic [WIDTH-1:0] pin,
  output logic [WIDTH-1:0] pout
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = pin;
    end else if (shift) begin
      q_d = {sin, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign pout = q_q;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer: one full adder, LSB first.
// Optional subtract port enabled by defining SERIAL_ADD_SUB_EN.
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [WIDTH-1:0] a_sr, b_sr;
  logic [WIDTH-1:0] b_ld;
  logic             cin_ld;
  logic             accept, run;
  logic [1:0]       fa;
  logic             unused_sr;

`ifdef SERIAL_ADD_SUB_EN
  // Subtract as a + ~b + 1; cout then reads as "no borrow".
  assign b_ld   = sub ? ~b : b;
  assign cin_ld = sub ? 1'b1 : cin;
`else
  assign b_ld   = b;
  assign cin_ld = cin;
`endif

  assign accept = (state_q == IDLE) && start;
  assign run    = (state_q == RUN);
  assign fa     = fulladder(a_sr[0], b_sr[0], carry_q);

  serial_shift_reg #(.WIDTH(WIDTH)) u_a_sr (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (run),
    .sin   (1'b0),
    .pin   (a),
    .pout  (a_sr)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_b_sr (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (run),
    .sin   (1'b0),
    .pin   (b_ld),
    .pout  (b_sr)
  );

  serial_shift_reg #(.WIDTH(WIDTH)) u_sum_sr (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (run),
    .sin   (fa[0]),
    .pin   ({WIDTH{1'b0}}),
    .pout  (sum)
  );

  // Only the LSB of each operand feeds the adder.
  assign unused_sr = ^{a_sr[WIDTH-1:1], b_sr[WIDTH-1:1]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          carry_d = cin_ld;
        end
      end
      RUN: begin
        carry_d = fa[1];
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST) begin
          cout_d  = fa[1];
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign busy = (state_q == RUN) || (state_q == DONE);
  assign done = (state_q == DONE);
  assign cout = cout_q;

endmodule
